inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Sequential RISC-V RV32I instruction encoder: the encoding counterpart of the opcode decode in the CPU control path.
- Accepts decoded instruction fields through a valid/ready handshake and packs them into 32-bit instruction words.
- Streams the words, with incrementing byte addresses, into the instruction-memory write port; used for boot-time program loading and for self-test stimulus generation.
- Runs a programmed burst of COUNT instructions per start pulse.

Parameters:
- ADDR_W, 8, width of the instruction-memory byte address; addresses wrap modulo 2^ADDR_W.
- CNT_W, 8, width of the burst instruction count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle burst start pulse; honoured only in IDLE.
- base_addr  input  ADDR_W  byte address of the first word; sampled on start.
- count  input  CNT_W  number of instructions in the burst; sampled on start.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder accepts the bundle this cycle.
- op_class  input  4  0=R, 1=I-arith, 2=LOAD, 3=STORE, 4=BRANCH, 5=JAL, 6=JALR, 7=LUI, 8=AUIPC, 9=SYSTEM; 10-15 illegal.
- rd, rs1, rs2  input  5 each  register indices.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field; used by R only.
- imm  input  32  signed immediate; for LUI/AUIPC it is the full upper value.
- wr_en  output  1  memory write request; held until accepted.
- wr_addr  output  ADDR_W  byte address of the write.
- wr_data  output  32  encoded instruction word.
- wr_ready  input  1  memory accepts the write when wr_en && wr_ready.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse at burst end.
- err  output  1  sticky error flag; cleared by rst or by an accepted start.

Behaviour:
- Reset:
  - All outputs are 0 (wr_en, wr_addr, wr_data, in_ready, busy, done, err).
  - State goes to IDLE; remaining count and address counter clear.
  - A reset mid-burst abandons any pending write; no further writes are issued.
- States are IDLE, RUN, DRAIN.
- IDLE:
  - On start, latch base_addr into addr_q and count into remaining, clear err, and go to RUN.
  - If count==0, go to DRAIN directly instead.
- RUN:
  - in_ready = (remaining!=0) && (!wr_en || wr_ready). This is combinational and gives one instruction per cycle under no backpressure.
  - When in_valid && in_ready: encode, load wr_data, set wr_addr=addr_q and wr_en=1, then addr_q+=4 and remaining-=1.
  - When the last bundle is accepted (remaining becomes 0), go to DRAIN.
- DRAIN:
  - Wait until !wr_en, or until the wr_en && wr_ready handshake of the final word.
  - Then pulse done for 1 cycle and return to IDLE.
- Output register: wr_data and wr_addr change only on acceptance; they are stable while wr_en && !wr_ready. wr_en clears after a handshake unless a new bundle is accepted in the same cycle.
- Latency: a bundle accepted in cycle N is presented on the write port in cycle N+1.
- start while busy or in DRAIN is ignored.
- Encoding uses standard RV32I formats, with opcodes R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, SYSTEM 1110011.
  - JALR forces funct3=000.
  - SYSTEM uses the I format.
  - LUI and AUIPC place imm[31:12].
- Legality checks:
  - I, LOAD, STORE, JALR, SYSTEM: imm must be in [-2048, 2047].
  - BRANCH: imm in [-4096, 4094] and even.
  - JAL: imm in [-2^20, 2^20-2] and even.
  - LUI, AUIPC: imm[11:0] must be 0.
- Violation or illegal op_class:
  - The bundle is still consumed and counted.
  - wr_data = 32'h00000013 (NOP) to preserve address alignment.
  - err is set.
- Address wrap: addr_q is 0xFC+4 → 0x00 (ADDR_W=8) with no error.

Test Plan:
- I-type: start base_addr=0x10, count=1; I-type rd=1, rs1=0, funct3=0, imm=5 → one write, wr_addr=0x10, wr_data=0x00500093, done pulse one cycle after the handshake, err=0.
- Mixed burst: count=3 with no backpressure.
  - Inputs: STORE rs1=1, rs2=2, funct3=010, imm=8; BRANCH rs1=1, rs2=2, funct3=000, imm=-4; LUI rd=5, imm=0x12345000.
  - Required writes: 0x0020A423@0x10, 0xFE208EE3@0x14, 0x123452B7@0x18, on consecutive cycles.
- Backpressure: wr_ready=0 for 3 cycles during a burst → wr_en, wr_addr and wr_data stay stable, in_ready=0 throughout, and no bundle is lost or duplicated.
- Errors: I-type imm=2048, then op_class=12 → both write 0x00000013, err=1 until the next start, and addresses still advance by 4.
- Edge cases:
  - count=0 → no writes, done 1 cycle after start.
  - base_addr=0xFC with count=2 → writes at 0xFC then 0x00.
  - start during RUN is ignored.
- Reset mid-burst: assert rst with wr_en pending → next cycle all outputs are 0, no further writes, and a new start works normally.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: sequential RV32I instruction encoder.
// Accepts decoded fields over a valid/ready handshake, packs them into 32-bit
// RV32I words and streams them to an instruction-memory write port at
// incrementing byte addresses. Each start pulse runs a burst of `count` words.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, base_addr, count  burst launch (sampled only in IDLE)
//   in_valid / in_ready      field-bundle handshake
//   op_class, rd, rs1, rs2,
//   funct3, funct7, imm      decoded instruction fields
//   wr_en/wr_addr/wr_data    registered write request, held until wr_ready
//   wr_ready                 memory accepts write when wr_en && wr_ready
//   busy                     high while in RUN
//   done                     one-cycle pulse at burst end
//   err                      sticky: illegal class or out-of-range immediate
module inst_encoder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_class,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    typedef enum logic [3:0] {
        OP_R = 4'd0, OP_I = 4'd1, OP_LOAD = 4'd2, OP_STORE = 4'd3,
        OP_BRANCH = 4'd4, OP_JAL = 4'd5, OP_JALR = 4'd6, OP_LUI = 4'd7,
        OP_AUIPC = 4'd8, OP_SYSTEM = 4'd9
    } op_class_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [31:0]         enc_word;
    logic                enc_ok;
    logic                fits12, fits13, fits21;

    // Signed range tests: the value fits when all bits above the field's
    // sign bit equal that sign bit.
    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        enc_word = NOP;
        enc_ok   = 1'b0;
        case (op_class_t'(op_class))
            OP_R: begin
                enc_word = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
                enc_ok   = 1'b1;
            end
            OP_I: begin
                enc_word = {imm[11:0], rs1, funct3, rd, 7'b0010011};
                enc_ok   = fits12;
            end
            OP_LOAD: begin
                enc_word = {imm[11:0], rs1, funct3, rd, 7'b0000011};
                enc_ok   = fits12;
            end
            OP_STORE: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
                enc_ok   = fits12;
            end
            OP_BRANCH: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                            imm[4:1], imm[11], 7'b1100011};
                enc_ok   = fits13 & ~imm[0];
            end
            OP_JAL: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
                enc_ok   = fits21 & ~imm[0];
            end
            OP_JALR: begin
                enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
                enc_ok   = fits12;
            end
            OP_LUI: begin
                enc_word = {imm[31:12], rd, 7'b0110111};
                enc_ok   = ~(|imm[11:0]);
            end
            OP_AUIPC: begin
                enc_word = {imm[31:12], rd, 7'b0010111};
                enc_ok   = ~(|imm[11:0]);
            end
            OP_SYSTEM: begin
                enc_word = {imm[11:0], rs1, funct3, rd, 7'b1110011};
                enc_ok   = fits12;
            end
            default: begin
                enc_word = NOP;
                enc_ok   = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        err_d       = err_q;
        in_ready    = 1'b0;

        // A completed handshake frees the output register; a same-cycle
        // acceptance below re-arms it.
        if (wr_en_q && wr_ready) begin
            wr_en_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = count;
                    err_d       = 1'b0;
                    state_d     = (count == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                in_ready = (remaining_q != '0) && (!wr_en_q || wr_ready);
                if (in_valid && in_ready) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = addr_q;
                    wr_data_d   = enc_ok ? enc_word : NOP;
                    if (!enc_ok) begin
                        err_d = 1'b1;
                    end
                    addr_d      = addr_q + ADDR_W'(4);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!wr_en_q || wr_ready) begin
                    wr_en_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Testbench for inst_encoder: scoreboard of expected writes filled when a
// bundle is accepted, drained by a write-port monitor on handshakes.
module tb_inst_encoder;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  count = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        op_class = '0;
    logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]        funct3 = '0;
    logic [6:0]        funct7 = '0;
    logic [31:0]       imm = '0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ready = 1'b1;
    logic              busy, done, err;

    inst_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .count(count), .in_valid(in_valid), .in_ready(in_ready),
        .op_class(op_class), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    exp_t sb[$];
    int   wr_cyc[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   bp_mode = 0;   // 0: always ready, 1: never ready, 2: random

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = 1'b0;
                default: wr_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Write-port monitor.
    always @(negedge clk) begin
        if (!rst && wr_en && wr_ready) begin
            checks++;
            wr_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", wr_addr, wr_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
    end

    // Reference encoder: returns {legal, word}.
    function automatic logic [32:0] ref_enc(input logic [3:0] op, input logic [4:0] rdv,
                                            input logic [4:0] r1, input logic [4:0] r2,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] im);
        int          s;
        logic        ok;
        logic [31:0] w;
        s  = im;
        ok = 1'b1;
        w  = 32'h13;
        case (op)
            4'd0: w = {f7, r2, r1, f3, rdv, 7'b0110011};
            4'd1: begin ok = (s >= -2048) && (s <= 2047); w = {im[11:0], r1, f3, rdv, 7'b0010011}; end
            4'd2: begin ok = (s >= -2048) && (s <= 2047); w = {im[11:0], r1, f3, rdv, 7'b0000011}; end
            4'd3: begin ok = (s >= -2048) && (s <= 2047); w = {im[11:5], r2, r1, f3, im[4:0], 7'b0100011}; end
            4'd4: begin
                ok = (s >= -4096) && (s <= 4094) && !im[0];
                w  = {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'b1100011};
            end
            4'd5: begin
                ok = (s >= -1048576) && (s <= 1048574) && !im[0];
                w  = {im[20], im[10:1], im[11], im[19:12], rdv, 7'b1101111};
            end
            4'd6: begin ok = (s >= -2048) && (s <= 2047); w = {im[11:0], r1, 3'b000, rdv, 7'b1100111}; end
            4'd7: begin ok = (im[11:0] == 12'h0); w = {im[31:12], rdv, 7'b0110111}; end
            4'd8: begin ok = (im[11:0] == 12'h0); w = {im[31:12], rdv, 7'b0010111}; end
            4'd9: begin ok = (s >= -2048) && (s <= 2047); w = {im[11:0], r1, f3, rdv, 7'b1110011}; end
            default: ok = 1'b0;
        endcase
        if (!ok) w = 32'h0000_0013;
        return {ok, w};
    endfunction

    task automatic drive_fields(input logic [3:0] op, input logic [4:0] rdv, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] im);
        op_class = op; rd = rdv; rs1 = r1; rs2 = r2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    // Present one bundle; push the expected write when it is accepted.
    // Entered and left at posedge+1.
    task automatic send(input logic [3:0] op, input logic [4:0] rdv, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] im, input logic [ADDR_W-1:0] ea, input logic [31:0] ed);
        bit got;
        got = 1'b0;
        drive_fields(op, rdv, r1, r2, f3, f7, im);
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{ea, ed});
                got = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
        end
    endtask

    task automatic start_burst(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c);
        start = 1'b1; base_addr = b; count = c;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done; exp_lat > 0 fixes the negedge on which it must appear.
    task automatic wait_done(input int exp_lat, input string name);
        int  k;
        bit  got;
        got = 1'b0;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s done_timeout done=%b required=1", name, done);
        end else if (exp_lat > 0 && k != exp_lat) begin
            errors++;
            $display("FAIL %s done_latency got=%0d required=%0d", name, k, exp_lat);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL %s done_pulse done=%b busy=%b required 0 0", name, done, busy);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s pending_writes got=%0d required=0", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data, in_ready, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs wr_en=%b wr_addr=%h wr_data=%h in_ready=%b busy=%b done=%b err=%b required all 0",
                     wr_en, wr_addr, wr_data, in_ready, busy, done, err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_itype();
        start_burst(8'h10, 8'd1);
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 8'h10, 32'h0050_0093);
        wait_done(2, "itype");
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL itype_err got=%b required=0", err);
        end
    endtask

    task automatic test_back_to_back();
        wr_cyc.delete();
        start_burst(8'h10, 8'd3);
        send(4'd3, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 8'h10, 32'h0020_A423);
        send(4'd4, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -32'sd4, 8'h14, 32'hFE20_8EE3);
        send(4'd7, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000, 8'h18, 32'h1234_52B7);
        wait_done(2, "mixed");
        checks++;
        if (wr_cyc.size() != 3) begin
            errors++;
            $display("FAIL mixed_write_count got=%0d required=3", wr_cyc.size());
        end else if (wr_cyc[1] - wr_cyc[0] != 1 || wr_cyc[2] - wr_cyc[1] != 1) begin
            errors++;
            $display("FAIL mixed_consecutive gaps got=%0d,%0d required=1,1",
                     wr_cyc[1] - wr_cyc[0], wr_cyc[2] - wr_cyc[1]);
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] e1, e2, e3;
        e1 = ref_enc(4'd1, 5'd3, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
        e2 = ref_enc(4'd2, 5'd4, 5'd2, 5'd0, 3'b010, 7'd0, -32'sd16);
        e3 = ref_enc(4'd6, 5'd1, 5'd5, 5'd0, 3'b111, 7'd0, 32'd100);
        start_burst(8'h20, 8'd3);
        send(4'd1, 5'd3, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1, 8'h20, e1[31:0]);
        bp_mode = 1;
        drive_fields(4'd2, 5'd4, 5'd2, 5'd0, 3'b010, 7'd0, -32'sd16);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({wr_en, in_ready, wr_addr, wr_data} !== {1'b1, 1'b0, 8'h20, e1[31:0]}) begin
                errors++;
                $display("FAIL backpressure_hold wr_en=%b in_ready=%b addr=%h data=%h required 1 0 20 %h",
                         wr_en, in_ready, wr_addr, wr_data, e1[31:0]);
            end
            @(posedge clk);
            #1;
        end
        bp_mode = 0;
        send(4'd2, 5'd4, 5'd2, 5'd0, 3'b010, 7'd0, -32'sd16, 8'h24, e2[31:0]);
        send(4'd6, 5'd1, 5'd5, 5'd0, 3'b111, 7'd0, 32'd100, 8'h28, e3[31:0]);
        wait_done(2, "backpressure");
    endtask

    task automatic test_errors();
        start_burst(8'h30, 8'd2);
        send(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 8'h30, 32'h0000_0013);
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set got=%b required=1", err);
        end
        @(posedge clk);
        #1;
        send(4'd12, 5'd2, 5'd3, 5'd4, 3'd0, 7'd0, 32'd0, 8'h34, 32'h0000_0013);
        wait_done(2, "errors");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got=%b required=1", err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_count_zero();
        int n;
        n = wr_cyc.size();
        start_burst(8'h00, 8'd0);
        wait_done(2, "count_zero");
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_err got=%b required=0", err);
        end
        checks++;
        if (wr_cyc.size() != n) begin
            errors++;
            $display("FAIL count_zero_writes got=%0d required=0", wr_cyc.size() - n);
        end
    endtask

    task automatic test_wrap();
        start_burst(8'hFC, 8'd2);
        send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 8'hFC, 32'h0020_81B3);
        send(4'd8, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 8'h00, 32'h0000_1217);
        wait_done(2, "wrap");
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_err got=%b required=0", err);
        end
    endtask

    task automatic test_start_ignored();
        logic [32:0] e1, e2;
        e1 = ref_enc(4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        e2 = ref_enc(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048);
        start_burst(8'h40, 8'd2);
        send(4'd9, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 8'h40, e1[31:0]);
        start_burst(8'h80, 8'd5);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_in_run_busy got=%b required=1", busy);
        end
        send(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048, 8'h44, e2[31:0]);
        wait_done(2, "start_ignored");
    endtask

    task automatic test_random();
        logic [32:0] e;
        logic [31:0] im;
        logic [3:0]  op;
        logic [4:0]  a, b, c;
        logic [2:0]  f3;
        logic [6:0]  f7;
        bit          exp_err;
        exp_err = 1'b0;
        bp_mode = 2;
        start_burst(8'h80, 8'd12);
        for (int i = 0; i < 12; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 5'($urandom); b = 5'($urandom); c = 5'($urandom);
            f3 = 3'($urandom); f7 = 7'($urandom);
            case ($urandom_range(0, 3))
                0:       im = {{20{1'b0}}, 12'($urandom)} ^ ($urandom_range(0, 1) ? 32'hFFFF_F000 : 32'h0);
                1:       im = $urandom & 32'h0000_1FFE;
                2:       im = $urandom;
                default: im = $urandom & 32'hFFFF_F000;
            endcase
            e = ref_enc(op, a, b, c, f3, f7, im);
            if (!e[32]) exp_err = 1'b1;
            send(op, a, b, c, f3, f7, im, 8'(8'h80 + 4 * i), e[31:0]);
        end
        bp_mode = 0;
        wait_done(-1, "random");
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL random_err got=%b required=%b", err, exp_err);
        end
    endtask

    task automatic test_reset_midburst();
        bit seen;
        start_burst(8'h50, 8'd3);
        send(4'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd7, 8'h50,
             ref_enc(4'd1, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd7));
        send(4'd1, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd9, 8'h54,
             ref_enc(4'd1, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd9));
        bp_mode = 1;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("FAIL midburst_pending wr_en=%b required=1", wr_en);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if ({wr_en, wr_addr, wr_data, in_ready, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL midburst_reset_outputs wr_en=%b wr_addr=%h wr_data=%h in_ready=%b busy=%b done=%b err=%b required all 0",
                     wr_en, wr_addr, wr_data, in_ready, busy, done, err);
        end
        bp_mode = 0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (wr_en) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL midburst_no_writes wr_en_seen=1 required=0");
        end
        @(posedge clk);
        #1;
        start_burst(8'h60, 8'd1);
        send(4'd0, 5'd7, 5'd6, 5'd5, 3'd0, 7'h20, 32'd0, 8'h60, 32'h4053_03B3);
        wait_done(2, "after_reset");
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_itype();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_count_zero();
        test_wrap();
        test_start_ignored();
        test_random();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
